// File: rtl/pipeline_mem_lsu.sv
// MEM stage and MEM/WB pipeline register: req/ack data-memory access, load alignment/extension, stall.
// Optional build macro MEM_TIMEOUT_EN adds an ack watchdog of TIMEOUT cycles.
module pipeline_mem_lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_valid,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [1:0]  MEM_Size,
    input  logic        MEM_Signed,
    input  logic [31:0] MEM_ALUOut,
    input  logic [31:0] MEM_WrData,
    input  logic [1:0]  MEM_RegDst,
    input  logic [1:0]  MEM_MemtoReg,
    input  logic [4:0]  MEM_WrReg,
    input  logic [30:0] MEM_PC,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] WB_inA,
    output logic [31:0] WB_inB,
    output logic [30:0] WB_PC,
    output logic [4:0]  WB_WrReg,
    output logic [1:0]  WB_RegDst,
    output logic [1:0]  WB_MemtoReg,
    output logic        AdE
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd1:    is_misaligned = a[0];
            2'd2:    is_misaligned = 1'b0;
            default: is_misaligned = (a != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd1:    byte_en = 4'b0011 << a;
            2'd2:    byte_en = 4'b0001 << a;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'd1:    store_lanes = {2{d[15:0]}};
            2'd2:    store_lanes = {4{d[7:0]}};
            default: store_lanes = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic sgn,
                                                input logic [1:0] a, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (size)
            2'd1:    load_extend = {{16{sgn & h[15]}}, h};
            2'd2:    load_extend = {{24{sgn & b[7]}}, b};
            default: load_extend = rd;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] hold_alu_q, hold_alu_d;
    logic [30:0] hold_pc_q, hold_pc_d;
    logic [4:0]  hold_wrreg_q, hold_wrreg_d;
    logic [1:0]  hold_regdst_q, hold_regdst_d, hold_m2r_q, hold_m2r_d, hold_size_q, hold_size_d;
    logic        hold_signed_q, hold_signed_d, hold_read_q, hold_read_d;
    logic [31:0] wb_a_q, wb_a_d, wb_b_q, wb_b_d;
    logic [30:0] wb_pc_q, wb_pc_d;
    logic [4:0]  wb_wrreg_q, wb_wrreg_d;
    logic [1:0]  wb_regdst_q, wb_regdst_d, wb_m2r_q, wb_m2r_d;
    logic        ade_q, ade_d;
    logic        memop_s, mis_s, stall_s, timeout_hit_s;

    assign memop_s = MEM_valid & (MEM_MemRead | MEM_MemWrite);
    assign mis_s   = is_misaligned(MEM_Size, MEM_ALUOut[1:0]);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Watchdog count of REQ cycles spent without ack; cleared while idle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (!mem_ack) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign timeout_hit_s = (state_q == ST_REQ) && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit_s = 1'b0;
`endif

    // Next-state, memory-request and MEM/WB register computation.
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        hold_alu_d    = hold_alu_q;
        hold_pc_d     = hold_pc_q;
        hold_wrreg_d  = hold_wrreg_q;
        hold_regdst_d = hold_regdst_q;
        hold_m2r_d    = hold_m2r_q;
        hold_size_d   = hold_size_q;
        hold_signed_d = hold_signed_q;
        hold_read_d   = hold_read_q;
        wb_a_d        = 32'd0;
        wb_b_d        = 32'd0;
        wb_pc_d       = 31'd0;
        wb_wrreg_d    = 5'd0;
        wb_regdst_d   = 2'd0;
        wb_m2r_d      = 2'd0;
        ade_d         = 1'b0;
        stall_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (memop_s && !mis_s) begin
                    stall_s       = 1'b1;
                    state_d       = ST_REQ;
                    req_d         = 1'b1;
                    we_d          = MEM_MemWrite;
                    addr_d        = {MEM_ALUOut[31:2], 2'b00};
                    be_d          = byte_en(MEM_Size, MEM_ALUOut[1:0]);
                    wdata_d       = store_lanes(MEM_Size, MEM_WrData);
                    hold_alu_d    = MEM_ALUOut;
                    hold_pc_d     = MEM_PC;
                    hold_wrreg_d  = MEM_WrReg;
                    hold_regdst_d = MEM_RegDst;
                    hold_m2r_d    = MEM_MemtoReg;
                    hold_size_d   = MEM_Size;
                    hold_signed_d = MEM_Signed;
                    hold_read_d   = MEM_MemRead & ~MEM_MemWrite;
                end else if (memop_s) begin
                    ade_d = 1'b1;
                end else if (MEM_valid) begin
                    wb_a_d      = MEM_ALUOut;
                    wb_pc_d     = MEM_PC;
                    wb_wrreg_d  = MEM_WrReg;
                    wb_regdst_d = MEM_RegDst;
                    wb_m2r_d    = MEM_MemtoReg;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    // Ack beats a simultaneous watchdog expiry.
                    wb_a_d      = hold_alu_q;
                    wb_b_d      = hold_read_q ? load_extend(hold_size_q, hold_signed_q,
                                                            hold_alu_q[1:0], mem_rdata) : 32'd0;
                    wb_pc_d     = hold_pc_q;
                    wb_wrreg_d  = hold_wrreg_q;
                    wb_regdst_d = hold_regdst_q;
                    wb_m2r_d    = hold_m2r_q;
                    req_d       = 1'b0;
                    we_d        = 1'b0;
                    be_d        = 4'b0000;
                    state_d     = ST_IDLE;
                end else if (timeout_hit_s) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    be_d    = 4'b0000;
                    ade_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
                be_d    = 4'b0000;
            end
        endcase
    end

    // State, request, holding and MEM/WB registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= 32'd0;
            be_q          <= 4'b0000;
            wdata_q       <= 32'd0;
            hold_alu_q    <= 32'd0;
            hold_pc_q     <= 31'd0;
            hold_wrreg_q  <= 5'd0;
            hold_regdst_q <= 2'd0;
            hold_m2r_q    <= 2'd0;
            hold_size_q   <= 2'd0;
            hold_signed_q <= 1'b0;
            hold_read_q   <= 1'b0;
            wb_a_q        <= 32'd0;
            wb_b_q        <= 32'd0;
            wb_pc_q       <= 31'd0;
            wb_wrreg_q    <= 5'd0;
            wb_regdst_q   <= 2'd0;
            wb_m2r_q      <= 2'd0;
            ade_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            hold_alu_q    <= hold_alu_d;
            hold_pc_q     <= hold_pc_d;
            hold_wrreg_q  <= hold_wrreg_d;
            hold_regdst_q <= hold_regdst_d;
            hold_m2r_q    <= hold_m2r_d;
            hold_size_q   <= hold_size_d;
            hold_signed_q <= hold_signed_d;
            hold_read_q   <= hold_read_d;
            wb_a_q        <= wb_a_d;
            wb_b_q        <= wb_b_d;
            wb_pc_q       <= wb_pc_d;
            wb_wrreg_q    <= wb_wrreg_d;
            wb_regdst_q   <= wb_regdst_d;
            wb_m2r_q      <= wb_m2r_d;
            ade_q         <= ade_d;
        end
    end

    assign stall       = stall_s;
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_be      = be_q;
    assign mem_wdata   = wdata_q;
    assign WB_inA      = wb_a_q;
    assign WB_inB      = wb_b_q;
    assign WB_PC       = wb_pc_q;
    assign WB_WrReg    = wb_wrreg_q;
    assign WB_RegDst   = wb_regdst_q;
    assign WB_MemtoReg = wb_m2r_q;
    assign AdE         = ade_q;

endmodule
